// File: rtl/alu_seq_unit.sv
// Sequential ALU with valid/ready handshake and a one-deep registered result stage.
// Optional feature macro ALU_SEQ_MUL_EN adds an iterative shift-add multiplier (R-type func 6).
module alu_seq_unit #(
    parameter int DATA_W = 20,
    parameter int FUNC_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        aluop,
    input  logic [FUNC_W-1:0] func,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result,
    output logic [3:0]        ctrl,
    output logic              zero,
    output logic              err,
    output logic              busy
);
    localparam logic [3:0] CTRL_ILL = 4'b1111;
`ifdef ALU_SEQ_MUL_EN
    localparam logic [3:0] CTRL_MUL = 4'b1101;
`endif

    // Any func bit above bit 3 makes the code illegal, hence the zero-extended compare.
    function automatic logic [3:0] decode(input logic [2:0] op, input logic [FUNC_W-1:0] fn);
        logic [5:0] f6;
        logic [3:0] c;
        f6 = 6'(fn);
        c  = CTRL_ILL;
        case (op)
            3'b000: begin
                case (f6)
                    6'd1:    c = 4'b0001;
                    6'd2:    c = 4'b0010;
                    6'd3:    c = 4'b0011;
                    6'd4:    c = 4'b0100;
                    6'd5:    c = 4'b0101;
`ifdef ALU_SEQ_MUL_EN
                    6'd6:    c = CTRL_MUL;
`endif
                    default: c = CTRL_ILL;
                endcase
            end
            3'b001:  c = 4'b0110;
            3'b010:  c = 4'b0111;
            3'b011:  c = 4'b1000;
            3'b101:  c = 4'b1001;
            3'b100:  c = 4'b1010;
            3'b110:  c = 4'b1011;
            3'b111:  c = 4'b1100;
            default: c = CTRL_ILL;
        endcase
        return c;
    endfunction

    function automatic logic [DATA_W-1:0] compute(input logic [3:0] c,
                                                  input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
        logic [DATA_W-1:0] r;
        r = '0;
        case (c)
            4'b0001, 4'b0110, 4'b1000,
            4'b1001, 4'b1010, 4'b1100: r = a + b;
            4'b0010:                   r = a - b;
            4'b0011, 4'b0111:          r = a & b;
            4'b0100:                   r = a | b;
            4'b0101:                   r = DATA_W'($signed(a) < $signed(b));
            4'b1011:                   r = DATA_W'(a == b);
            default:                   r = '0;
        endcase
        return r;
    endfunction

    logic              out_free_s, accept_s, load_s;
    logic [3:0]        dec_s, load_ctrl_s;
    logic [DATA_W-1:0] load_res_s;
    logic              out_valid_q, out_valid_d, zero_q, zero_d, err_q, err_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic [3:0]        ctrl_q, ctrl_d;

    assign out_free_s = !out_valid_q || out_ready;
    assign dec_s      = decode(aluop, func);
    assign accept_s   = in_valid && in_ready;

`ifdef ALU_SEQ_MUL_EN
    typedef enum logic [1:0] {IDLE, MUL_RUN, MUL_HOLD} state_t;
    localparam int CNT_W = $clog2(DATA_W + 1);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d, step_sum_s;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    assign step_sum_s = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign in_ready   = (state_q == IDLE) && out_free_s && !rst;
    assign busy       = (state_q != IDLE);

    // FSM next state, shift-add step and selection of what loads the result stage.
    always_comb begin
        state_d     = state_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        load_s      = 1'b0;
        load_res_s  = '0;
        load_ctrl_s = CTRL_ILL;
        case (state_q)
            IDLE: begin
                if (accept_s && (dec_s == CTRL_MUL)) begin
                    state_d  = MUL_RUN;
                    mcand_d  = op_a;
                    mplier_d = op_b;
                    acc_d    = '0;
                    cnt_d    = CNT_W'(DATA_W);
                end else if (accept_s) begin
                    load_s      = 1'b1;
                    load_res_s  = compute(dec_s, op_a, op_b);
                    load_ctrl_s = dec_s;
                end else begin
                    state_d = IDLE;
                end
            end
            MUL_RUN: begin
                acc_d    = step_sum_s;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    if (out_free_s) begin
                        load_s      = 1'b1;
                        load_res_s  = step_sum_s;
                        load_ctrl_s = CTRL_MUL;
                        state_d     = IDLE;
                    end else begin
                        state_d = MUL_HOLD;
                    end
                end else begin
                    state_d = MUL_RUN;
                end
            end
            MUL_HOLD: begin
                if (out_free_s) begin
                    load_s      = 1'b1;
                    load_res_s  = acc_q;
                    load_ctrl_s = CTRL_MUL;
                    state_d     = IDLE;
                end else begin
                    state_d = MUL_HOLD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state and multiplier datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end
`else
    assign in_ready = out_free_s && !rst;
    assign busy     = 1'b0;

    // Every accepted op completes in a single cycle.
    always_comb begin
        load_s      = accept_s;
        load_res_s  = compute(dec_s, op_a, op_b);
        load_ctrl_s = dec_s;
    end
`endif

    // Result stage: a new load wins over consumption on the same edge.
    always_comb begin
        result_d    = result_q;
        ctrl_d      = ctrl_q;
        zero_d      = zero_q;
        err_d       = err_q;
        out_valid_d = out_valid_q;
        if (load_s) begin
            result_d    = load_res_s;
            ctrl_d      = load_ctrl_s;
            zero_d      = (load_res_s == '0);
            err_d       = (load_ctrl_s == CTRL_ILL);
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Result stage registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            ctrl_q      <= 4'b0000;
            zero_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            ctrl_q      <= ctrl_d;
            zero_q      <= zero_d;
            err_q       <= err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign ctrl      = ctrl_q;
    assign zero      = zero_q;
    assign err       = err_q;
endmodule

// File: tb/tb_alu_seq_unit.sv
// Self-checking bench for alu_seq_unit: directed cases plus a randomized run
// scored against an arithmetic reference model. Honours ALU_SEQ_MUL_EN if defined.
module tb_alu_seq_unit;
    localparam int DW = 20;
    localparam int FW = 4;

    typedef struct {
        longint     res;
        logic [3:0] ctrl;
        logic       zero;
        logic       err;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst, in_valid, in_ready, out_valid, out_ready;
    logic [2:0]    aluop;
    logic [FW-1:0] func;
    logic [DW-1:0] op_a, op_b, result;
    logic [3:0]    ctrl;
    logic          zero, err, busy;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    alu_seq_unit #(.DATA_W(DW), .FUNC_W(FW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .aluop(aluop), .func(func), .op_a(op_a), .op_b(op_b),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .ctrl(ctrl), .zero(zero), .err(err), .busy(busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: operation semantics from plain integer arithmetic.
    function automatic exp_t model(input logic [2:0] op, input logic [FW-1:0] fn,
                                   input longint a, input longint b);
        exp_t   e;
        longint m, sa, sb;
        m  = (64'd1 << DW) - 1;
        sa = (a >= (64'd1 << (DW - 1))) ? a - (64'd1 << DW) : a;
        sb = (b >= (64'd1 << (DW - 1))) ? b - (64'd1 << DW) : b;
        e.res  = 0;
        e.ctrl = 4'hF;
        case (op)
            3'd0: begin
                case (int'(fn))
                    1: begin e.ctrl = 4'h1; e.res = (a + b) & m; end
                    2: begin e.ctrl = 4'h2; e.res = (a - b) & m; end
                    3: begin e.ctrl = 4'h3; e.res = a & b; end
                    4: begin e.ctrl = 4'h4; e.res = a | b; end
                    5: begin e.ctrl = 4'h5; e.res = (sa < sb) ? 1 : 0; end
`ifdef ALU_SEQ_MUL_EN
                    6: begin e.ctrl = 4'hD; e.res = (a * b) & m; end
`endif
                    default: e.ctrl = 4'hF;
                endcase
            end
            3'd1: begin e.ctrl = 4'h6; e.res = (a + b) & m; end
            3'd2: begin e.ctrl = 4'h7; e.res = a & b; end
            3'd3: begin e.ctrl = 4'h8; e.res = (a + b) & m; end
            3'd5: begin e.ctrl = 4'h9; e.res = (a + b) & m; end
            3'd4: begin e.ctrl = 4'hA; e.res = (a + b) & m; end
            3'd6: begin e.ctrl = 4'hB; e.res = (a == b) ? 1 : 0; end
            3'd7: begin e.ctrl = 4'hC; e.res = (a + b) & m; end
            default: e.ctrl = 4'hF;
        endcase
        e.err  = (e.ctrl == 4'hF);
        e.zero = (e.res == 0);
        return e;
    endfunction

    // Present a request and hold it until accepted; returns just after the accepting edge.
    task automatic send(input logic [2:0] op, input logic [FW-1:0] fn,
                        input logic [DW-1:0] a, input logic [DW-1:0] b, output bit ok);
        logic rdy;
        ok = 1'b0;
        in_valid = 1'b1; aluop = op; func = fn; op_a = a; op_b = b;
        for (int i = 0; i < 64 && !ok; i++) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk); #1;
            if (rdy) ok = 1'b1;
        end
        in_valid = 1'b0;
        if (!ok) check_eq("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_op(input string tag, input logic [2:0] op, input logic [FW-1:0] fn,
                         input logic [DW-1:0] a, input logic [DW-1:0] b);
        exp_t e;
        bit   ok;
        int   n;
        e = model(op, fn, longint'(a), longint'(b));
        send(op, fn, a, b, ok);
        if (ok) begin
            if (e.ctrl == 4'hD) begin
                check_eq({tag, "_busy"}, 32'(busy), 32'd1);
                n = 0;
                while (!out_valid && n < 64) begin
                    @(posedge clk); #1;
                    n++;
                end
                check_eq({tag, "_latency"}, 32'(n), 32'(DW));
            end else begin
                check_eq({tag, "_valid"}, 32'(out_valid), 32'd1);
            end
            check_eq({tag, "_result"}, 32'(result), 32'(e.res));
            check_eq({tag, "_ctrl"}, 32'(ctrl), 32'(e.ctrl));
            check_eq({tag, "_zero"}, 32'(zero), 32'(e.zero));
            check_eq({tag, "_err"}, 32'(err), 32'(e.err));
        end
    endtask

    // One randomized cycle: observe at negedge, drive just after posedge.
    task automatic rand_cycle(input bit allow_new);
        exp_t e;
        bit   acc;
        @(negedge clk);
        if (busy === 1'b0) begin
            check_eq("rnd_out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
            check_eq("rnd_in_ready", 32'(in_ready), 32'(exp_q.size() == 0 || out_ready));
        end else begin
            check_eq("rnd_in_ready_busy", 32'(in_ready), 32'd0);
        end
`ifndef ALU_SEQ_MUL_EN
        check_eq("rnd_busy_tied", 32'(busy), 32'd0);
`endif
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("rnd_unexpected_result", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_eq("rnd_result", 32'(result), 32'(e.res));
                check_eq("rnd_ctrl", 32'(ctrl), 32'(e.ctrl));
                check_eq("rnd_zero", 32'(zero), 32'(e.zero));
                check_eq("rnd_err", 32'(err), 32'(e.err));
            end
        end
        acc = in_valid && in_ready;
        if (acc) exp_q.push_back(model(aluop, func, longint'(op_a), longint'(op_b)));
        @(posedge clk); #1;
        if (acc || !in_valid) begin
            in_valid = allow_new && ($urandom_range(0, 2) != 0);
            aluop    = 3'($urandom_range(0, 7));
            func     = ($urandom_range(0, 3) == 0) ? FW'($urandom_range(0, 15))
                                                   : FW'($urandom_range(1, 6));
            op_a     = DW'($urandom());
            op_b     = ($urandom_range(0, 3) == 0) ? op_a : DW'($urandom());
        end
        out_ready = allow_new ? ($urandom_range(0, 3) != 0) : 1'b1;
    endtask

    initial begin
        bit ok;
        bit rose;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        aluop = 3'd0; func = '0; op_a = '0; op_b = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_result", 32'(result), 32'd0);
        check_eq("rst_ctrl", 32'(ctrl), 32'd0);
        check_eq("rst_zero", 32'(zero), 32'd0);
        check_eq("rst_err", 32'(err), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        #1;
        check_eq("post_rst_in_ready", 32'(in_ready), 32'd1);

        do_op("add",     3'd0, 4'd1, 20'h00005, 20'h00003);
        do_op("slt_neg", 3'd0, 4'd5, 20'hFFFFF, 20'h00001);
        do_op("slt_pos", 3'd0, 4'd5, 20'h00001, 20'hFFFFF);
        do_op("sub_wrap",3'd0, 4'd2, 20'h00000, 20'h00001);
        do_op("beq_eq",  3'd6, 4'd0, 20'h00007, 20'h00007);
        do_op("beq_ne",  3'd6, 4'd0, 20'h00007, 20'h00008);
        do_op("illegal", 3'd0, 4'd9, 20'h12345, 20'h54321);
        do_op("func0",   3'd0, 4'd0, 20'h00001, 20'h00001);
        do_op("add_ovf", 3'd0, 4'd1, 20'hFFFFF, 20'h00001);
        do_op("and",     3'd0, 4'd3, 20'hF0F0F, 20'h0FF00);
        do_op("or",      3'd0, 4'd4, 20'hF0000, 20'h0000F);
        do_op("addi",    3'd1, 4'd7, 20'h10000, 20'h00abc);
        do_op("andi",    3'd2, 4'd0, 20'hABCDE, 20'h0FFF0);
        do_op("stw",     3'd3, 4'd0, 20'h00100, 20'h00020);
        do_op("load",    3'd4, 4'd0, 20'h00200, 20'h00004);
        do_op("store",   3'd5, 4'd0, 20'h00300, 20'h00008);
        do_op("jmem",    3'd7, 4'd0, 20'h80000, 20'h80000);
        do_op("mul",     3'd0, 4'd6, 20'h00123, 20'h00010);
        @(posedge clk); #1;

        // Backpressure: second request held, first result stable.
        out_ready = 1'b0;
        send(3'd0, 4'd1, 20'h00010, 20'h00020, ok);
        check_eq("bp_first", 32'(result), 32'h30);
        in_valid = 1'b1; aluop = 3'd0; func = 4'd1; op_a = 20'h00100; op_b = 20'h00200;
        repeat (3) begin
            @(negedge clk);
            check_eq("bp_in_ready", 32'(in_ready), 32'd0);
            check_eq("bp_stable", 32'(result), 32'h30);
            check_eq("bp_valid", 32'(out_valid), 32'd1);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        check_eq("bp_release_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_eq("bp_second_valid", 32'(out_valid), 32'd1);
        check_eq("bp_second", 32'(result), 32'h300);
        @(posedge clk); #1;
        check_eq("bp_drained", 32'(out_valid), 32'd0);

        // Multiply with the consumer stalled: result appears and then holds.
        out_ready = 1'b0;
        do_op("mul_stall", 3'd0, 4'd6, 20'hFFFFF, 20'hFFFFF);
        repeat (2) @(posedge clk);
        #1;
        check_eq("mul_stall_hold_valid", 32'(out_valid), 32'd1);
        check_eq("mul_stall_hold_ctrl", 32'(ctrl), 32'(model(3'd0, 4'd6, 64'hFFFFF, 64'hFFFFF).ctrl));
        out_ready = 1'b1;
        @(posedge clk); #1;
        check_eq("mul_stall_drained", 32'(out_valid), 32'd0);

        // Reset mid-operation, with a request presented during reset.
        send(3'd0, 4'd6, 20'h00055, 20'h00003, ok);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1; in_valid = 1'b1; aluop = 3'd0; func = 4'd1; op_a = 20'h1; op_b = 20'h1;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        #1;
        check_eq("rst_mid_valid", 32'(out_valid), 32'd0);
        check_eq("rst_mid_busy", 32'(busy), 32'd0);
        check_eq("rst_mid_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_mid_result", 32'(result), 32'd0);
        rose = 1'b0;
        repeat (30) begin
            @(posedge clk); #1;
            if (out_valid) rose = 1'b1;
        end
        check_eq("rst_abort_no_result", 32'(rose), 32'd0);

        // Randomized run against the reference model, then drain.
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        for (int c = 0; c < 600; c++) rand_cycle(1'b1);
        for (int c = 0; c < 40; c++) rand_cycle(1'b0);
        check_eq("rnd_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/alu_seq_unit.md
ALU_SEQ_UNIT -- requirements
Module: alu_seq_unit

Interface
REQ-001 Parameter DATA_W, default 20, operand/result width in bits (legal range 8..32).
REQ-002 Parameter FUNC_W, default 4, R-type function field width (legal range 4..6).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  request present on aluop/func/op_a/op_b.
REQ-006 in_ready  output  1  unit accepts a request this cycle; transfer when in_valid && in_ready.
REQ-007 aluop  input  3  operation class; 000 = R-type.
REQ-008 func  input  FUNC_W  R-type function code; upper bits above bit 3 must be 0 for a legal code.
REQ-009 op_a, op_b  input  DATA_W each  operands.
REQ-010 out_valid  output  1  result registers hold an unconsumed result.
REQ-011 out_ready  input  1  consumer takes the result; transfer when out_valid && out_ready.
REQ-012 result  output  DATA_W  registered result.
REQ-013 ctrl  output  4  registered decoded ALU control code of the op that produced result.
REQ-014 zero  output  1  registered; 1 when result == 0.
REQ-015 err  output  1  registered; 1 when the op was an illegal code.
REQ-016 busy  output  1  1 while a multi-cycle op is in progress.

Function
REQ-017 Decode: aluop 000 with func 1 ADD/ctrl 0001, 2 SUB/0010, 3 AND/0011, 4 OR/0100, 5 SLT/0101, 6 MUL/1101 (macro only); aluop 001 ADDI/0110, 010 ANDI/0111, 011 STW/1000, 101 STORE/1001, 100 LOAD/1010, 110 BEQ/1011, 111 JMEM/1100.
REQ-018 Ops: ADD, ADDI, STW, STORE, LOAD, JMEM -> op_a+op_b; SUB -> op_a-op_b; AND, ANDI -> op_a&op_b; OR -> op_a|op_b; all modulo 2^DATA_W, carry discarded.
REQ-019 SLT -> 1 if op_a < op_b as signed two's complement, else 0; BEQ -> 1 if op_a == op_b, else 0 (zero-extended).
REQ-020 Illegal code -> result 0, ctrl 1111, err 1, zero 1, latency 1.
REQ-021 FSM states IDLE, MUL_RUN, MUL_HOLD; reset state IDLE.
REQ-022 in_ready = (state == IDLE) && (!out_valid || out_ready) && !rst.
REQ-023 Single-cycle op accepted at edge N: result/ctrl/zero/err loaded and out_valid 1 after edge N; throughput one per cycle with out_ready held high.
REQ-024 out_valid clears on the edge where out_ready is sampled high, unless a new result loads on the same edge, in which case it stays 1.
REQ-025 result/ctrl/zero/err stay stable while out_valid && !out_ready.
REQ-026 MUL accept: IDLE->MUL_RUN, latch operands, counter = DATA_W, busy 1; one shift-add step per cycle, LSB of op_b first.
REQ-027 Counter reaches 0 with output free (!out_valid || out_ready): load low DATA_W bits of product, ctrl 1101, out_valid 1, ->IDLE; otherwise ->MUL_HOLD.
REQ-028 MUL_HOLD: wait until output free, then load and ->IDLE; busy 1 in MUL_RUN and MUL_HOLD.
REQ-029 Unstalled MUL: out_valid rises DATA_W edges after the accepting edge.
REQ-030 in_valid while in_ready is 0 is ignored; the sender holds the request.

Reset
REQ-031 rst high at an edge: state IDLE, out_valid 0, result 0, ctrl 0000, zero 0, err 0, busy 0, counter 0.
REQ-032 rst mid-MUL aborts the op; no result is produced.
REQ-033 rst dominates a simultaneous accept.

Configuration
REQ-034 Macro ALU_SEQ_MUL_EN defined: MUL (aluop 000, func 6) is supported per REQ-026..029, and the FSM includes MUL_RUN/MUL_HOLD.
REQ-035 Macro ALU_SEQ_MUL_EN undefined: func 6 is illegal (REQ-020), no multiplier state is built, busy is tied 0, and every op has latency 1.

Verification (DATA_W=20)
REQ-036 Reset then ADD 0x00005+0x00003, out_ready=1 -> one cycle later result 0x00008, ctrl 0001, zero 0, err 0.
REQ-037 SLT op_a=0xFFFFF, op_b=0x00001 -> result 1; SUB 0x00000-0x00001 -> result 0xFFFFF; BEQ 7,7 -> result 1, ctrl 1011.
REQ-038 Illegal code: aluop 000, func 9 -> result 0, ctrl 1111, err 1, zero 1.
REQ-039 Backpressure: out_ready=0 with two back-to-back ADDs -> second request held (in_ready 0) and first result stable; out_ready=1 -> second result follows on the next cycle.
REQ-040 Macro on: MUL 0x00123*0x00010 -> busy 1, out_valid after 20 edges, result 0x01230, ctrl 1101; MUL with out_ready=0 -> MUL_HOLD, out_valid only after the prior result drains.
REQ-041 rst asserted at cycle 5 of a MUL -> out_valid stays 0, busy 0, in_ready 1 on the cycle after rst drops; macro off: MUL -> err 1 after 1 cycle.
